// File: rtl/pet_stat_scheduler.sv
// pet_stat_scheduler: shared ms timebase, three per-stat period timers and a
// single arbitrated update path for the energy, hunger and entertainment stats.
// At most one stat changes per clock; feed requests outrank timer expiries and
// timer expiries are served round-robin.
module pet_stat_scheduler #(
   parameter int unsigned CLK_PER_MS = 50000,
   parameter int unsigned ENERGY_MS  = 40000,
   parameter int unsigned HUNGER_MS  = 10000,
   parameter int unsigned FUN_MS     = 20000,
   parameter int unsigned STAT_MAX   = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] state_i,
   input  logic       feed_i,
   input  logic       test_load_i,
   input  logic [3:0] test_sel_i,
   output logic [2:0] energy_o,
   output logic [2:0] hunger_o,
   output logic [2:0] fun_o,
   output logic       ms_tick_o,
   output logic       upd_valid_o,
   output logic [1:0] upd_id_o,
   output logic       upd_dir_o
);

   localparam int unsigned PW     = $clog2(CLK_PER_MS);
   localparam int unsigned MAX_EH = (ENERGY_MS > HUNGER_MS) ? ENERGY_MS : HUNGER_MS;
   localparam int unsigned MAX_MS = (MAX_EH > FUN_MS) ? MAX_EH : FUN_MS;
   localparam int unsigned TW     = $clog2(MAX_MS + 1);
   localparam int unsigned SW     = 3;

   localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);
   localparam logic [TW-1:0] E_LAST   = TW'(ENERGY_MS - 1);
   localparam logic [TW-1:0] H_LAST   = TW'(HUNGER_MS - 1);
   localparam logic [TW-1:0] F_LAST   = TW'(FUN_MS - 1);

   localparam logic [SW-1:0] SMAX = SW'(STAT_MAX);
   localparam logic [SW-1:0] P4   = (STAT_MAX < 4) ? SMAX : 3'd4;
   localparam logic [SW-1:0] P2   = (STAT_MAX < 2) ? SMAX : 3'd2;

   localparam logic [1:0] ID_E = 2'd0;
   localparam logic [1:0] ID_H = 2'd1;
   localparam logic [1:0] ID_F = 2'd2;

   localparam logic [3:0] ST_SLEEP   = 4'd3;
   localparam logic [3:0] ST_PLAYING = 4'd6;
   localparam logic [3:0] ST_DEATH   = 4'd8;

   // Wrap value of the timer that belongs to stat i
   function automatic logic [TW-1:0] tmr_last(input int i);
      logic [TW-1:0] v;
      case (i)
         0:       v = E_LAST;
         1:       v = H_LAST;
         default: v = F_LAST;
      endcase
      return v;
   endfunction

   // Next stat id in energy -> hunger -> fun -> energy order
   function automatic logic [1:0] next_id(input logic [1:0] id);
      return (id == ID_F) ? ID_E : id + 2'd1;
   endfunction

   // Preset table packed as {energy, hunger, fun}
   function automatic logic [3*SW-1:0] preset(input logic [3:0] sel);
      logic [3*SW-1:0] v;
      case (sel)
         4'd1:       v = {SMAX, SMAX, SMAX};
         4'd2:       v = {P4,   P4,   P4};
         4'd3, 4'd4: v = {P2,   SMAX, SMAX};
         4'd5:       v = {SMAX, P2,   SMAX};
         4'd6:       v = {P2,   P2,   SMAX};
         4'd7, 4'd8: v = {SMAX, SMAX, P2};
         default:    v = '0;
      endcase
      return v;
   endfunction

   // State registers
   logic [PW-1:0] pre_q;
   logic          tick_q;
   logic [TW-1:0] tmr_q [3];
   logic [2:0]    tmr_pend_q;
   logic          feed_pend_q;
   logic          feed_prev_q;
   logic [1:0]    ptr_q;
   logic [SW-1:0] stat_q [3];
   logic          upd_valid_q;
   logic [1:0]    upd_id_q;
   logic          upd_dir_q;

   // Next-state values
   logic [PW-1:0] pre_d;
   logic          tick_d;
   logic [TW-1:0] tmr_d [3];
   logic [2:0]    tmr_pend_d;
   logic          feed_pend_d;
   logic [1:0]    ptr_d;
   logic [SW-1:0] stat_d [3];
   logic          upd_valid_d;
   logic [1:0]    upd_id_d;
   logic          upd_dir_d;

   // Arbitration and update datapath
   logic          gnt_valid;
   logic          gnt_feed;
   logic [1:0]    gnt_id;
   logic [2:0]    gnt_mask;
   logic [1:0]    cand1;
   logic [1:0]    cand2;
   logic [SW-1:0] cur_val;
   logic [SW-1:0] nxt_val;
   logic          inc;
   logic          clamped;
   logic [2:0]    tmr_wrap;
   logic          feed_edge;
   logic          dead;
   logic          load;

   assign dead      = (state_i == ST_DEATH);
   assign load      = test_load_i && (test_sel_i >= 4'd1) && (test_sel_i <= 4'd9);
   assign feed_edge = feed_i & ~feed_prev_q;
   assign cand1     = next_id(ptr_q);
   assign cand2     = next_id(cand1);

   // Grant selection: feed first, then timer pendings round-robin from the pointer
   always_comb begin
      gnt_valid = 1'b0;
      gnt_feed  = 1'b0;
      gnt_id    = ID_E;
      if (feed_pend_q) begin
         gnt_valid = 1'b1;
         gnt_feed  = 1'b1;
         gnt_id    = ID_H;
      end else if (tmr_pend_q[ptr_q]) begin
         gnt_valid = 1'b1;
         gnt_id    = ptr_q;
      end else if (tmr_pend_q[cand1]) begin
         gnt_valid = 1'b1;
         gnt_id    = cand1;
      end else if (tmr_pend_q[cand2]) begin
         gnt_valid = 1'b1;
         gnt_id    = cand2;
      end
   end

   // Timer pending bit consumed by this cycle's grant
   always_comb begin
      gnt_mask = 3'b000;
      if (gnt_valid && !gnt_feed) begin
         gnt_mask = 3'b001 << gnt_id;
      end
   end

   // Direction of the granted update and its saturated result
   always_comb begin
      cur_val = stat_q[0];
      inc     = 1'b0;
      case (gnt_id)
         ID_H: begin
            cur_val = stat_q[1];
            inc     = gnt_feed;
         end
         ID_F: begin
            cur_val = stat_q[2];
            inc     = (state_i == ST_PLAYING);
         end
         default: begin
            cur_val = stat_q[0];
            inc     = (state_i == ST_SLEEP);
         end
      endcase
      clamped = inc ? (cur_val >= SMAX) : (cur_val == '0);
      nxt_val = inc ? cur_val + SW'(1) : cur_val - SW'(1);
   end

   // Timer wrap detection, only meaningful on ms tick cycles
   always_comb begin
      tmr_wrap = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tmr_wrap[i] = tick_q && (tmr_q[i] == tmr_last(i));
      end
   end

   // Next-state logic: prescaler, timers, pendings, pointer, stats and update strobe
   always_comb begin
      pre_d       = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
      tick_d      = (pre_d == PRE_LAST);
      for (int i = 0; i < 3; i++) begin
         tmr_d[i]  = tmr_q[i];
         stat_d[i] = stat_q[i];
      end
      tmr_pend_d  = tmr_pend_q;
      feed_pend_d = feed_pend_q;
      ptr_d       = ptr_q;
      upd_valid_d = 1'b0;
      upd_id_d    = 2'd0;
      upd_dir_d   = 1'b0;

      if (load) begin
         {stat_d[0], stat_d[1], stat_d[2]} = preset(test_sel_i);
         for (int i = 0; i < 3; i++) begin
            tmr_d[i] = '0;
         end
         tmr_pend_d  = 3'b000;
         feed_pend_d = 1'b0;
      end else if (dead) begin
         tmr_pend_d  = 3'b000;
         feed_pend_d = 1'b0;
      end else begin
         if (tick_q) begin
            for (int i = 0; i < 3; i++) begin
               tmr_d[i] = tmr_wrap[i] ? '0 : tmr_q[i] + TW'(1);
            end
         end
         tmr_pend_d  = (tmr_pend_q & ~gnt_mask) | tmr_wrap;
         feed_pend_d = (feed_pend_q & ~gnt_feed) | feed_edge;
         if (gnt_valid) begin
            if (!gnt_feed) begin
               ptr_d = next_id(gnt_id);
            end
            if (!clamped) begin
               for (int i = 0; i < 3; i++) begin
                  if (gnt_id == 2'(i)) begin
                     stat_d[i] = nxt_val;
                  end
               end
               upd_valid_d = 1'b1;
               upd_id_d    = gnt_id;
               upd_dir_d   = inc;
            end
         end
      end
   end

   // State register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q       <= '0;
         tick_q      <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            tmr_q[i]  <= '0;
            stat_q[i] <= SMAX;
         end
         tmr_pend_q  <= 3'b000;
         feed_pend_q <= 1'b0;
         feed_prev_q <= 1'b0;
         ptr_q       <= ID_E;
         upd_valid_q <= 1'b0;
         upd_id_q    <= 2'd0;
         upd_dir_q   <= 1'b0;
      end else begin
         pre_q       <= pre_d;
         tick_q      <= tick_d;
         for (int i = 0; i < 3; i++) begin
            tmr_q[i]  <= tmr_d[i];
            stat_q[i] <= stat_d[i];
         end
         tmr_pend_q  <= tmr_pend_d;
         feed_pend_q <= feed_pend_d;
         feed_prev_q <= feed_i;
         ptr_q       <= ptr_d;
         upd_valid_q <= upd_valid_d;
         upd_id_q    <= upd_id_d;
         upd_dir_q   <= upd_dir_d;
      end
   end

   assign energy_o    = stat_q[0];
   assign hunger_o    = stat_q[1];
   assign fun_o       = stat_q[2];
   assign ms_tick_o   = tick_q;
   assign upd_valid_o = upd_valid_q;
   assign upd_id_o    = upd_id_q;
   assign upd_dir_o   = upd_dir_q;

endmodule

// File: tb/tb_pet_stat_scheduler.sv
// Directed bench for pet_stat_scheduler with small periods so every scenario
// fits in a few dozen cycles. Cycle 0 is the cycle right after reset release;
// ms ticks fall on odd cycles.
module tb_pet_stat_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] state;
   logic       feed;
   logic       test_load;
   logic [3:0] test_sel;
   logic [2:0] energy;
   logic [2:0] hunger;
   logic [2:0] fun;
   logic       ms_tick;
   logic       upd_valid;
   logic [1:0] upd_id;
   logic       upd_dir;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   pet_stat_scheduler #(
      .CLK_PER_MS(2),
      .ENERGY_MS (4),
      .HUNGER_MS (2),
      .FUN_MS    (3),
      .STAT_MAX  (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .state_i    (state),
      .feed_i     (feed),
      .test_load_i(test_load),
      .test_sel_i (test_sel),
      .energy_o   (energy),
      .hunger_o   (hunger),
      .fun_o      (fun),
      .ms_tick_o  (ms_tick),
      .upd_valid_o(upd_valid),
      .upd_id_o   (upd_id),
      .upd_dir_o  (upd_dir)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      state     = 4'd1;
      feed      = 1'b0;
      test_load = 1'b0;
      test_sel  = 4'd0;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      state     = 4'd1;
      feed      = 1'b0;
      test_load = 1'b0;
      test_sel  = 4'd0;
      step();
      checks++; if (energy !== 3'd5) begin fails++; $display("FAIL reset energy: got %0d expected 5", energy); end
      checks++; if (hunger !== 3'd5) begin fails++; $display("FAIL reset hunger: got %0d expected 5", hunger); end
      checks++; if (fun !== 3'd5) begin fails++; $display("FAIL reset fun: got %0d expected 5", fun); end
      checks++; if (ms_tick !== 1'b0) begin fails++; $display("FAIL reset ms_tick: got %b expected 0", ms_tick); end
      checks++; if (upd_valid !== 1'b0 || upd_id !== 2'd0 || upd_dir !== 1'b0) begin fails++; $display("FAIL reset upd: got v%b id%0d d%b expected all 0", upd_valid, upd_id, upd_dir); end
      rst = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         checks++; if (ms_tick !== 1'((c % 2) == 1)) begin fails++; $display("FAIL reset_run ms_tick cyc %0d: got %b expected %b", c, ms_tick, (c % 2) == 1); end
         if (c == 4) begin
            checks++; if (hunger !== 3'd5 || upd_valid !== 1'b0) begin fails++; $display("FAIL reset_run early hunger cyc 4: got h%0d v%b expected h5 v0", hunger, upd_valid); end
         end
         if (c == 5) begin
            checks++; if (hunger !== 3'd4) begin fails++; $display("FAIL reset_run first hunger: got %0d expected 4", hunger); end
            checks++; if (upd_valid !== 1'b1 || upd_id !== 2'd1 || upd_dir !== 1'b0) begin fails++; $display("FAIL reset_run first upd: got v%b id%0d d%b expected v1 id1 d0", upd_valid, upd_id, upd_dir); end
            checks++; if (energy !== 3'd5 || fun !== 3'd5) begin fails++; $display("FAIL reset_run others: got e%0d f%0d expected e5 f5", energy, fun); end
         end
      end
   endtask

   // Free run from reset: round-robin order including a three-way simultaneous expiry
   task automatic test_round_robin();
      int exp_id [1:27];
      for (int c = 1; c <= 27; c++) exp_id[c] = -1;
      exp_id[5]  = 1; exp_id[7]  = 2; exp_id[9]  = 0; exp_id[10] = 1;
      exp_id[13] = 2; exp_id[14] = 1; exp_id[17] = 0; exp_id[18] = 1;
      exp_id[19] = 2; exp_id[21] = 1; exp_id[25] = 2; exp_id[26] = 0;
      do_reset();
      for (int c = 1; c <= 27; c++) begin
         step();
         checks++;
         if (upd_valid !== 1'(exp_id[c] >= 0)) begin
            fails++; $display("FAIL rr upd_valid cyc %0d: got %b expected %b", c, upd_valid, exp_id[c] >= 0);
         end else if (exp_id[c] >= 0 && (upd_id !== 2'(exp_id[c]) || upd_dir !== 1'b0)) begin
            fails++; $display("FAIL rr upd cyc %0d: got id%0d d%b expected id%0d d0", c, upd_id, upd_dir, exp_id[c]);
         end
      end
      checks++; if (energy !== 3'd2 || hunger !== 3'd0 || fun !== 3'd1) begin fails++; $display("FAIL rr final stats: got e%0d h%0d f%0d expected e2 h0 f1", energy, hunger, fun); end
   endtask

   task automatic test_feed_hold();
      int n_inc = 0;
      do_reset();
      test_load = 1'b1; test_sel = 4'd5;
      step();
      test_load = 1'b0; feed = 1'b1;
      checks++; if (energy !== 3'd5 || hunger !== 3'd2 || fun !== 3'd5 || upd_valid !== 1'b0) begin fails++; $display("FAIL feed_hold preset5: got e%0d h%0d f%0d v%b expected e5 h2 f5 v0", energy, hunger, fun, upd_valid); end
      for (int c = 2; c <= 24; c++) begin
         step();
         if (c == 21) feed = 1'b0;
         if (upd_valid === 1'b1 && upd_dir === 1'b1) n_inc++;
         if (c == 3) begin
            checks++; if (hunger !== 3'd3 || upd_valid !== 1'b1 || upd_id !== 2'd1 || upd_dir !== 1'b1) begin fails++; $display("FAIL feed_hold grant: got h%0d v%b id%0d d%b expected h3 v1 id1 d1", hunger, upd_valid, upd_id, upd_dir); end
         end
      end
      checks++; if (n_inc != 1) begin fails++; $display("FAIL feed_hold increments: got %0d expected 1", n_inc); end
   endtask

   // Feed and hunger timer pend together; an invalid preset strobe is ignored meanwhile
   task automatic test_feed_contention();
      do_reset();
      test_load = 1'b1; test_sel = 4'd2;
      step();
      test_load = 1'b0;
      checks++; if (energy !== 3'd4 || hunger !== 3'd4 || fun !== 3'd4) begin fails++; $display("FAIL contention preset2: got e%0d h%0d f%0d expected 4/4/4", energy, hunger, fun); end
      step();
      test_load = 1'b1; test_sel = 4'd15;
      step();
      test_load = 1'b0; feed = 1'b1;
      step();
      checks++; if (upd_valid !== 1'b0 || hunger !== 3'd4) begin fails++; $display("FAIL contention cyc4: got v%b h%0d expected v0 h4", upd_valid, hunger); end
      step();
      checks++; if (upd_valid !== 1'b1 || upd_id !== 2'd1 || upd_dir !== 1'b1 || hunger !== 3'd5) begin fails++; $display("FAIL contention feed first: got v%b id%0d d%b h%0d expected v1 id1 d1 h5", upd_valid, upd_id, upd_dir, hunger); end
      step();
      checks++; if (upd_valid !== 1'b1 || upd_id !== 2'd1 || upd_dir !== 1'b0 || hunger !== 3'd4) begin fails++; $display("FAIL contention timer second: got v%b id%0d d%b h%0d expected v1 id1 d0 h4", upd_valid, upd_id, upd_dir, hunger); end
      step();
      checks++; if (upd_valid !== 1'b1 || upd_id !== 2'd2 || fun !== 3'd3) begin fails++; $display("FAIL contention fun: got v%b id%0d f%0d expected v1 id2 f3", upd_valid, upd_id, fun); end
      feed = 1'b0;
   endtask

   task automatic test_sleep_clamp();
      do_reset();
      state = 4'd3;
      for (int c = 1; c <= 9; c++) step();
      checks++; if (upd_valid !== 1'b0 || energy !== 3'd5) begin fails++; $display("FAIL sleep clamp: got v%b e%0d expected v0 e5", upd_valid, energy); end
      test_load = 1'b1; test_sel = 4'd3;
      step();
      test_load = 1'b0;
      checks++; if (energy !== 3'd2 || hunger !== 3'd5 || fun !== 3'd5 || upd_valid !== 1'b0) begin fails++; $display("FAIL sleep preset3: got e%0d h%0d f%0d v%b expected e2 h5 f5 v0", energy, hunger, fun, upd_valid); end
      for (int c = 11; c <= 19; c++) step();
      checks++; if (upd_valid !== 1'b1 || upd_id !== 2'd0 || upd_dir !== 1'b1 || energy !== 3'd3) begin fails++; $display("FAIL sleep recover: got v%b id%0d d%b e%0d expected v1 id0 d1 e3", upd_valid, upd_id, upd_dir, energy); end
      state = 4'd1;
   endtask

   task automatic test_death_and_reset();
      int n_upd  = 0;
      int n_tick = 0;
      do_reset();
      test_load = 1'b1; test_sel = 4'd9;
      step();
      checks++; if (energy !== 3'd0 || hunger !== 3'd0 || fun !== 3'd0 || upd_valid !== 1'b0) begin fails++; $display("FAIL death preset9: got e%0d h%0d f%0d v%b expected 0/0/0 v0", energy, hunger, fun, upd_valid); end
      test_sel = 4'd2; state = 4'd8;
      step();
      test_load = 1'b0;
      for (int i = 0; i < 100; i++) begin
         feed      = ((i % 3) == 0) && (i < 99);
         test_load = (i == 50);
         test_sel  = 4'd12;
         step();
         if (upd_valid === 1'b1) n_upd++;
         if (ms_tick === 1'b1) n_tick++;
      end
      test_load = 1'b0;
      feed      = 1'b0;
      checks++; if (n_upd != 0) begin fails++; $display("FAIL death updates: got %0d expected 0", n_upd); end
      checks++; if (n_tick != 50) begin fails++; $display("FAIL death ticks: got %0d expected 50", n_tick); end
      checks++; if (energy !== 3'd4 || hunger !== 3'd4 || fun !== 3'd4) begin fails++; $display("FAIL death frozen: got e%0d h%0d f%0d expected 4/4/4", energy, hunger, fun); end
      state = 4'd1;
      for (int c = 103; c <= 106; c++) step();
      checks++; if (upd_valid !== 1'b0 || hunger !== 3'd4) begin fails++; $display("FAIL revive cyc106: got v%b h%0d expected v0 h4", upd_valid, hunger); end
      step();
      checks++; if (upd_valid !== 1'b1 || upd_id !== 2'd1 || hunger !== 3'd3) begin fails++; $display("FAIL revive hunger: got v%b id%0d h%0d expected v1 id1 h3", upd_valid, upd_id, hunger); end
      step();
      step();
      checks++; if (upd_valid !== 1'b1 || upd_id !== 2'd2 || fun !== 3'd3) begin fails++; $display("FAIL revive fun: got v%b id%0d f%0d expected v1 id2 f3", upd_valid, upd_id, fun); end
      step();
      rst = 1'b1;
      #1;
      checks++; if (energy !== 3'd5 || hunger !== 3'd5 || fun !== 3'd5 || upd_valid !== 1'b0) begin fails++; $display("FAIL mid reset: got e%0d h%0d f%0d v%b expected 5/5/5 v0", energy, hunger, fun, upd_valid); end
      step();
      step();
      rst = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 4; c++) begin
         step();
         checks++; if (upd_valid !== 1'b0 || energy !== 3'd5 || hunger !== 3'd5) begin fails++; $display("FAIL post reset cyc %0d: got v%b e%0d h%0d expected v0 e5 h5", c, upd_valid, energy, hunger); end
      end
   endtask

   initial begin
      state     = 4'd1;
      feed      = 1'b0;
      test_load = 1'b0;
      test_sel  = 4'd0;
      test_reset();
      test_round_robin();
      test_feed_hold();
      test_feed_contention();
      test_sleep_clamp();
      test_death_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/pet_stat_scheduler.md
Name: pet_stat_scheduler

Overview:
Central scheduler for the pet's three vital statistics: energy, hunger and entertainment.
- Owns one shared ms timebase and three independent per-stat period timers.
- Arbitrates all stat changes (timer decay/recovery, feed requests, test presets) onto a single update path, so at most one stat changes per clock.
- Feeds stat values to the pet-state FSM and display logic; consumes the FSM state code to choose update direction.

Parameters:
CLK_PER_MS, 50000, clk cycles per ms tick (>=2)
ENERGY_MS, 40000, ms between energy updates
HUNGER_MS, 10000, ms between hunger decrements
FUN_MS, 20000, ms between entertainment updates
STAT_MAX, 5, saturation ceiling for every stat (<=7)

Ports:
clk  in  1  system clock
rst  in  1  reset
state_i  in  4  FSM state code (0 IDLE,1 NEUTRAL,2 TIRED,3 SLEEP,4 HUNGRY,5 SAD,6 PLAYING,7 BORED,8 DEATH,9 TEST)
feed_i  in  1  feed button level, already debounced
test_load_i  in  1  one-cycle strobe: load preset
test_sel_i  in  4  preset select, 1..9
energy_o  out  3  energy value
hunger_o  out  3  hunger value
fun_o  out  3  entertainment value
ms_tick_o  out  1  one-cycle pulse, once per ms
upd_valid_o  out  1  one-cycle pulse: a stat changed this cycle
upd_id_o  out  2  stat changed (0 energy, 1 hunger, 2 fun)
upd_dir_o  out  1  1 = increment, 0 = decrement

Behaviour:
Reset and clocking:
- Reset rst, asynchronous, active-high; clock clk.
- During/after reset: energy_o = hunger_o = fun_o = STAT_MAX; all counters, pendings and upd_* = 0; ms_tick_o = 0; RR pointer = energy.
- Single clock domain; no derived clocks.

Prescaler:
- Counts 0..CLK_PER_MS-1.
- ms_tick_o is high for the one cycle in which the count equals CLK_PER_MS-1.

Per-stat timers:
- Each timer advances only on ms_tick_o cycles and wraps at PERIOD-1.
- On the wrap cycle, the stat's timer-pending flag sets at the next edge.
- A new expiry while the flag is still set merges; it is not queued.

Feed:
- A rising edge of feed_i (registered compare against previous value) sets feed-pending.
- Holding feed_i high produces exactly one request.

Arbitration (combinational from pendings; one grant per cycle):
- Priority 1: feed-pending.
- Priority 2: timer pendings, round-robin energy→hunger→fun starting at the pointer.
- After a timer grant, the pointer moves to granted+1 (mod 3).
- A feed grant does not move the pointer.

Update direction, sampled from state_i in the grant cycle:
- energy: +1 if SLEEP, else −1.
- fun: +1 if PLAYING, else −1.
- hunger via timer: −1.
- hunger via feed: +1.

Apply and saturation:
- The granted pending clears and the stat updates at the same edge.
- upd_valid_o/upd_id_o/upd_dir_o are registered with that edge and held for one cycle.
- Clamp to [0, STAT_MAX]. A clamped update (−1 at 0, +1 at STAT_MAX) consumes the grant, leaves the value unchanged and does not assert upd_valid_o.

Latency:
- Uncontended timer: wrap in tick cycle N → pending at N+1 → value and upd_valid_o at N+2.
- Feed edge sampled at cycle N → hunger_o+1 and upd_valid_o at N+2.

DEATH (state_i = 8):
- Prescaler runs; per-stat timers hold.
- All pendings clear; feed edges are ignored; stats frozen.

Test load:
- Applies when test_load_i=1 and test_sel_i is 1..9; highest priority over any grant that cycle.
- Effects: loads preset (energy/hunger/fun), zeroes the three per-stat timers, clears all pendings. upd_valid_o stays 0 and the pointer is unchanged.
- Presets: 1: MAX/MAX/MAX; 2: 4/4/4; 3,4: 2/MAX/MAX; 5: MAX/2/MAX; 6: 2/2/MAX; 7,8: MAX/MAX/2; 9: 0/0/0.
- test_sel_i of 0 or 10..15: strobe ignored, normal operation continues.

Reset mid-operation: pendings, timers and the feed edge history are discarded immediately.

Test Plan:
(All with CLK_PER_MS=2, ENERGY_MS=4, HUNGER_MS=2, FUN_MS=3, STAT_MAX=5, state_i=NEUTRAL.)
- Release reset, run 8 cycles → ms_tick_o every 2nd cycle; first hunger update (dir 0) hunger_o=4 exactly 2 cycles after the 2nd tick; energy/fun still 5.
- Preset 1, then arrange simultaneous energy and fun pendings with pointer=energy → energy updates first, fun next cycle, pointer ends at energy (0).
- Hold feed_i high 20 cycles with hunger_o=3 → exactly one upd (id 1, dir 1), hunger_o=4.
- Feed edge in the same cycle as a hunger timer pending → feed grant first (+1), timer grant next cycle (−1); net value unchanged, two upd_valid_o pulses.
- state_i=SLEEP with energy=5: energy expiry → no upd_valid_o, energy_o stays 5. Then preset 3 → energy 2; next expiry → 3, dir 1.
- test_load_i with sel 9 → all stats 0; then state_i=DEATH → no updates over 100 cycles; test_sel_i=12 strobe → ignored; rst mid-pending → stats reset to 5, no upd_valid_o.
